// File: rtl/fp32_mul_seq.sv
// rtl/fp32_mul_seq.sv - iterative IEEE-754 binary32 multiplier, shift-add datapath
//
// Purpose: computes out = in1 * in2 (round-to-nearest-even) over a fixed
// 24/BITS_PER_CYCLE + 3 cycle schedule: IDLE -> UNPACK -> MULT -> NORM -> ROUND -> DONE.
// Latency does not depend on the operand values.
//
// Build option: define FP_MUL_SUBNORM_EN for full subnormal support
// (pre-normalised subnormal inputs, gradual underflow). Without it, subnormal
// inputs read as signed zero and tiny results flush to signed zero.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in1/in2 valid
//   in_ready   idle, operands accepted
//   in1, in2   binary32 operands
//   out_valid  out holds a result
//   out_ready  consumer takes out
//   out        binary32 product

module fp32_mul_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out
);

    localparam int         STEPS    = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] CNT_LOAD = 5'(STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t             state;
    logic [31:0]        a_q, b_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [47:0]        mcand_q;
    logic [23:0]        mplier_q;
    logic [47:0]        acc_q;
    logic [4:0]         cnt_q;
    logic               nan_q, inf_q, zero_q;
    logic [23:0]        mant_q;
    logic               guard_q, round_q, sticky_q, tiny_q;

`ifdef FP_MUL_SUBNORM_EN
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(23 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction
`endif

    // Splits one operand into a 24-bit significand with its leading one at
    // bit 23 (when nonzero) and a signed biased exponent.
    function automatic void decode(
        input  logic [31:0]       f,
        output logic [23:0]       m,
        output logic signed [9:0] x,
        output logic              is_nan,
        output logic              is_inf,
        output logic              is_zero
    );
        is_nan = (f[30:23] == 8'hFF) && (f[22:0] != 23'h0);
        is_inf = (f[30:23] == 8'hFF) && (f[22:0] == 23'h0);
`ifdef FP_MUL_SUBNORM_EN
        is_zero = (f[30:23] == 8'h00) && (f[22:0] == 23'h0);
        if (f[30:23] == 8'h00) begin
            // Subnormal: normalise so the multiplier always sees 1.xxx
            m = {1'b0, f[22:0]} << lzc24({1'b0, f[22:0]});
            x = 10'sd1 - $signed({5'b0, lzc24({1'b0, f[22:0]})});
        end else begin
            m = {1'b1, f[22:0]};
            x = $signed({2'b00, f[30:23]});
        end
`else
        is_zero = (f[30:23] == 8'h00);
        m = {1'b1, f[22:0]};
        x = $signed({2'b00, f[30:23]});
`endif
    endfunction

    // UNPACK decode
    logic [23:0]       ma, mb;
    logic signed [9:0] xa, xb, exp_sum;
    logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    always_comb begin
        decode(a_q, ma, xa, a_nan, a_inf, a_zero);
        decode(b_q, mb, xb, b_nan, b_inf, b_zero);
        exp_sum = xa + xb - 10'sd127;
    end

    // MULT: BITS_PER_CYCLE multiplier bits retired per cycle
    logic [47:0] partial;

    always_comb begin
        partial = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mplier_q[j]) partial = partial + (mcand_q << j);
        end
    end

    // NORM: bring the product to 1.xxx at bit 47, then form G/R/S
    logic [47:0]       n48, den;
    logic signed [9:0] e_n;
    logic              tiny, lost;
`ifdef FP_MUL_SUBNORM_EN
    logic signed [9:0] sh_full;
    logic [5:0]        sh;
`endif

    always_comb begin
        n48  = acc_q[47] ? acc_q : {acc_q[46:0], 1'b0};
        e_n  = exp_q + (acc_q[47] ? 10'sd1 : 10'sd0);
        tiny = (e_n <= 10'sd0);
        den  = n48;
        lost = 1'b0;
`ifdef FP_MUL_SUBNORM_EN
        sh_full = 10'sd1 - e_n;
        sh      = (sh_full > 10'sd48) ? 6'd48 : sh_full[5:0];
        if (tiny) begin
            // Denormalise onto the 2^-149 grid; everything shifted out is sticky
            den  = n48 >> sh;
            lost = |(n48 & ((48'd1 << sh) - 48'd1));
        end
`endif
    end

    // ROUND: RNE plus final result selection in precedence order
    logic              inc;
    logic [24:0]       mant_r;
    logic signed [9:0] exp_r;
    logic [22:0]       frac_r;
    logic [31:0]       result;

    always_comb begin
        inc    = guard_q & (round_q | sticky_q | mant_q[0]);
        mant_r = {1'b0, mant_q} + {24'b0, inc};
        exp_r  = exp_q + (mant_r[24] ? 10'sd1 : 10'sd0);
        frac_r = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        if (nan_q)
            result = 32'h7FC0_0000;
        else if (inf_q)
            result = {sign_q, 8'hFF, 23'h0};
        else if (zero_q)
            result = {sign_q, 31'h0};
        else if (tiny_q)
`ifdef FP_MUL_SUBNORM_EN
            // A carry into bit 23 yields exponent field 1, i.e. 2^-126
            result = {sign_q, 7'h00, mant_r[23], mant_r[22:0]};
`else
            result = {sign_q, 31'h0};
`endif
        else if (exp_r >= 10'sd255)
            result = {sign_q, 8'hFF, 23'h0};
        else
            result = {sign_q, exp_r[7:0], frac_r};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= 32'h0;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            zero_q    <= 1'b0;
            mant_q    <= '0;
            guard_q   <= 1'b0;
            round_q   <= 1'b0;
            sticky_q  <= 1'b0;
            tiny_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q      <= in1;
                        b_q      <= in2;
                        in_ready <= 1'b0;
                        state    <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign_q   <= a_q[31] ^ b_q[31];
                    exp_q    <= exp_sum;
                    mcand_q  <= {24'b0, ma};
                    mplier_q <= mb;
                    acc_q    <= '0;
                    cnt_q    <= CNT_LOAD;
                    nan_q    <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
                    inf_q    <= a_inf | b_inf;
                    zero_q   <= a_zero | b_zero;
                    state    <= S_MULT;
                end
                S_MULT: begin
                    acc_q    <= acc_q + partial;
                    mcand_q  <= mcand_q << BITS_PER_CYCLE;
                    mplier_q <= mplier_q >> BITS_PER_CYCLE;
                    if (cnt_q == 5'd0) state <= S_NORM;
                    else               cnt_q <= cnt_q - 5'd1;
                end
                S_NORM: begin
                    exp_q    <= e_n;
                    mant_q   <= den[47:24];
                    guard_q  <= den[23];
                    round_q  <= den[22];
                    sticky_q <= (|den[21:0]) | lost;
                    tiny_q   <= tiny;
                    state    <= S_ROUND;
                end
                S_ROUND: begin
                    out       <= result;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_mul_seq.sv
// tb/tb_fp32_mul_seq.sv - scoreboard bench for fp32_mul_seq at BITS_PER_CYCLE 1, 2, 4, 8

module tb_fp32_mul_seq;

`ifdef FP_MUL_SUBNORM_EN
    localparam bit SUBNORM = 1'b1;
`else
    localparam bit SUBNORM = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int       n_vec = 0;
    int       n_bad = 0;
    bit [3:0] lane_done = '0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expv;
        int          acc;
    } txn_t;

    function automatic void check(input int bpc, input string what,
                                  input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL bpc=%0d %s: got %08h expected %08h", bpc, what, act, expv);
        end
    endfunction

    // Magnitude of a binary32 value as an exact real
    function automatic real mag(input logic [31:0] f);
        real r;
        int  e;
        e = int'(f[30:23]);
        if (e == 0) begin
            r = real'(f[22:0]);
            for (int i = 0; i < 149; i++) r = r * 0.5;
        end else begin
            r = real'({1'b1, f[22:0]});
            if (e >= 150) for (int i = 0; i < e - 150; i++) r = r * 2.0;
            else          for (int i = 0; i < 150 - e; i++) r = r * 0.5;
        end
        return r;
    endfunction

    // Reference: exact product in double, then RNE to binary32
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s, an, ai, az, bn, bi, bz;
        real         p;
        logic [63:0] d, m, q, rem, half;
        int          fe, drop;
        s  = a[31] ^ b[31];
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        az = (a[30:23] == 8'h00) && (!SUBNORM || a[22:0] == 0);
        bz = (b[30:23] == 8'h00) && (!SUBNORM || b[22:0] == 0);
        if (an || bn) return 32'h7FC0_0000;
        if ((ai && bz) || (az && bi)) return 32'h7FC0_0000;
        if (ai || bi) return {s, 8'hFF, 23'h0};
        if (az || bz) return {s, 31'h0};
        p  = mag(a) * mag(b);
        d  = $realtobits(p);
        m  = {11'b0, 1'b1, d[51:0]};
        fe = int'(d[62:52]) - 1023 + 127;
        if (fe <= 0 && !SUBNORM) return {s, 31'h0};
        drop = (fe >= 1) ? 29 : 29 + (1 - fe);
        if (drop > 60) return {s, 31'h0};
        q    = m >> drop;
        rem  = m & ((64'd1 << drop) - 64'd1);
        half = 64'd1 << (drop - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (fe >= 1) begin
            if (q == (64'd1 << 24)) begin
                q  = q >> 1;
                fe = fe + 1;
            end
            if (fe >= 255) return {s, 8'hFF, 23'h0};
            return {s, 8'(fe), q[22:0]};
        end
        return {s, 31'(q)};
    endfunction

    function automatic logic [31:0] rand_normal();
        logic [7:0] e;
        if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(1, 254));
        else                           e = 8'($urandom_range(110, 144));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int BPC    = 1 << g;
        localparam int LAT    = 24 / BPC + 3;
        localparam int RST_AT = (LAT > 12) ? 10 : LAT - 2;

        logic        rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
        logic        in_ready, out_valid;
        logic [31:0] in1 = '0, in2 = '0, out;
        int          cyc = 0;
        txn_t        q[$];
        bit          held = 1'b0;
        logic        hs = 1'b0, v_e = 1'b0, r_e = 1'b1;
        logic [31:0] o_e = '0;

        fp32_mul_seq #(.BITS_PER_CYCLE(BPC)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
            .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
            .out(out)
        );

        // Values as seen by the DUT at the rising edge
        always @(posedge clk) begin
            cyc <= cyc + 1;
            hs  <= out_valid & out_ready;
            v_e <= out_valid;
            o_e <= out;
            r_e <= rst;
        end

        // Monitor
        initial forever begin
            txn_t t;
            @(negedge clk);
            if (r_e) begin
                held = 1'b0;
            end else begin
                if (v_e && !hs) begin
                    check(BPC, "hold_valid", {31'b0, out_valid}, 32'd1);
                    check(BPC, "hold_out", out, o_e);
                end
                if (hs) held = 1'b0;
                if (out_valid && !held) begin
                    if (q.size() == 0) begin
                        check(BPC, "spurious_out_valid", {31'b0, out_valid}, 32'd0);
                    end else begin
                        t    = q.pop_front();
                        held = 1'b1;
                        check(BPC, $sformatf("out %08h*%08h", t.a, t.b), out, t.expv);
                        check(BPC, "latency", 32'(cyc - t.acc), 32'(LAT));
                    end
                end
                check(BPC, "in_ready", {31'b0, in_ready},
                      {31'b0, !(q.size() > 0 || held)});
            end
        end

        task automatic issue(input logic [31:0] a, input logic [31:0] b);
            txn_t t;
            int   acc, k;
            in1 = a;
            in2 = b;
            in_valid = 1'b1;
            k = 0;
            while (!in_ready && k < 4 * LAT + 50) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) begin
                check(BPC, "accept_timeout", {31'b0, in_ready}, 32'd1);
                in_valid = 1'b0;
                return;
            end
            acc = cyc + 1;
            @(posedge clk);
            t.a = a;
            t.b = b;
            t.expv = ref_mul(a, b);
            t.acc = acc;
            q.push_back(t);
            @(negedge clk);
            in_valid = 1'b0;
        endtask

        task automatic drain();
            int k;
            k = 0;
            while ((q.size() > 0 || held) && k < 4 * LAT + 50) begin
                @(negedge clk);
                k++;
            end
            check(BPC, "drain_timeout", {31'b0, (q.size() > 0 || held)}, 32'd0);
        endtask

        // Driver
        initial begin
            int acc0, k;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check(BPC, "reset in_ready", {31'b0, in_ready}, 32'd1);
            check(BPC, "reset out_valid", {31'b0, out_valid}, 32'd0);
            check(BPC, "reset out", out, 32'h0);

            issue(32'h3FC0_0000, 32'h4030_0000);
            drain();

            // Back-pressure hold with ignored in_valid pulses
            out_ready = 1'b0;
            issue(32'hC060_0000, 32'hBFA0_0000);
            k = 0;
            while (!out_valid && k < 4 * LAT + 50) begin
                @(negedge clk);
                k++;
            end
            check(BPC, "hold wait out_valid", {31'b0, out_valid}, 32'd1);
            for (int i = 0; i < 10; i++) begin
                in1 = 32'h3F80_0000;
                in2 = 32'h4000_0000;
                in_valid = (i % 3 == 0);
                @(negedge clk);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            drain();

            issue(32'h0040_0000, 32'h4000_0000);
            issue(32'h7F80_0000, 32'h0000_0000);
            issue(32'h7F00_0000, 32'h4000_0000);
            issue(32'h8000_0000, 32'h3F80_0000);
            issue(32'h7FC1_2345, 32'h3F80_0000);
            issue(32'hFF80_0000, 32'h4000_0000);
            issue(32'h3F80_0001, 32'h3F80_0001);
            drain();

            // Reset mid-operation
            issue(32'h3FC0_0000, 32'h4030_0000);
            acc0 = cyc;
            while (cyc < acc0 + RST_AT - 1) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            q.delete();
            check(BPC, "rst out_valid", {31'b0, out_valid}, 32'd0);
            check(BPC, "rst in_ready", {31'b0, in_ready}, 32'd1);
            check(BPC, "rst out", out, 32'h0);
            repeat (LAT + 5) @(negedge clk);
            issue(32'h3F80_0000, 32'h3F80_0000);
            drain();

            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                issue(rand_normal(), rand_normal());
            end
            drain();
            lane_done[g] = 1'b1;
        end
    end

    initial begin
        int k;
        k = 0;
        while (lane_done != 4'hF && k < 40000) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (lane_done != 4'hF) begin
            n_bad++;
            $display("FAIL run_timeout: lanes done %04b expected 1111", lane_done);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
